// File: rtl/instr_mem_pipelined_if.sv
// Fetch/preload bus between the LC3 fetch stage and the instruction memory.
// master: drives fetch requests and preload writes, receives responses.
// slave : the memory; receives requests/loads, drives response and status.
interface instr_mem_pipelined_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned CNT_W = 16;

    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr_dout;
    logic                  instr_valid;
    logic                  addr_err;
    logic                  load_err;
    logic [CNT_W-1:0]      rd_count;

    modport master (
        output load_en, load_addr, load_data, rd_en, pc,
        input  instr_dout, instr_valid, addr_err, load_err, rd_count
    );

    modport slave (
        input  load_en, load_addr, load_data, rd_en, pc,
        output instr_dout, instr_valid, addr_err, load_err, rd_count
    );
endinterface

// File: rtl/instr_mem_pipelined.sv
// Pipelined instruction memory for the LC3 fetch stage.
// One fetch per cycle, fixed READ_LATENCY, side-band preload port,
// out-of-range detection on both fetch and load.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high; clears pipeline/counters, not the array
//   bus   - slave side of instr_mem_pipelined_if (load_*, rd_en/pc in;
//           instr_dout/instr_valid/addr_err/load_err/rd_count out)
module instr_mem_pipelined #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_mem_pipelined_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             rd_in_range_c;
    logic             ld_in_range_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [IDX_W-1:0] ld_idx_c;
    resp_t            stage_in_c [READ_LATENCY];
    resp_t            pipe       [READ_LATENCY];
    logic [CNT_W-1:0] rd_count_q;
    logic             load_err_q;

    // Range checks are full-width (one extra bit) so DEPTH == 2**ADDR_WIDTH never errors.
    always_comb begin
        rd_in_range_c = {1'b0, bus.pc} < DEPTH_C;
        ld_in_range_c = {1'b0, bus.load_addr} < DEPTH_C;
        rd_idx_c      = IDX_W'(bus.pc);
        ld_idx_c      = IDX_W'(bus.load_addr);
    end

    // Stage inputs: stage 0 takes the new request, stage i takes stage i-1.
    // The array read here sees the pre-edge contents, giving read-before-write.
    always_comb begin
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            stage_in_c[i] = '0;
        end
        stage_in_c[0].valid = bus.rd_en;
        stage_in_c[0].err   = bus.rd_en && !rd_in_range_c;
        stage_in_c[0].data  = rd_in_range_c ? mem[rd_idx_c] : FILL_WORD;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            stage_in_c[i] = pipe[i-1];
        end
    end

    // Preload write; the array is deliberately outside reset.
    always_ff @(posedge clock) begin
        if (bus.load_en && ld_in_range_c) begin
            mem[ld_idx_c] <= bus.load_data;
        end
    end

    // Response pipeline. The last stage is the output register: its data only
    // updates on a valid response so instr_dout holds between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
                pipe[i] <= stage_in_c[i];
            end
            pipe[READ_LATENCY-1].valid <= stage_in_c[READ_LATENCY-1].valid;
            pipe[READ_LATENCY-1].err   <= stage_in_c[READ_LATENCY-1].valid
                                          && stage_in_c[READ_LATENCY-1].err;
            if (stage_in_c[READ_LATENCY-1].valid) begin
                pipe[READ_LATENCY-1].data <= stage_in_c[READ_LATENCY-1].data;
            end
        end
    end

    // Saturating request counter and load error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            if (bus.rd_en && (rd_count_q != '1)) begin
                rd_count_q <= rd_count_q + CNT_W'(1);
            end
            load_err_q <= bus.load_en && !ld_in_range_c;
        end
    end

    assign bus.instr_dout  = pipe[READ_LATENCY-1].data;
    assign bus.instr_valid = pipe[READ_LATENCY-1].valid;
    assign bus.addr_err    = pipe[READ_LATENCY-1].err;
    assign bus.load_err    = load_err_q;
    assign bus.rd_count    = rd_count_q;
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Self-checking bench for instr_mem_pipelined: four instances with different
// depth/latency, a vector table, directed multi-cycle sequences and a
// randomized run against an array-based memory model.
module tb_instr_mem_pipelined;
    logic clock;
    logic rst_a, rst_b, rst_c, rst_d;
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_mem_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_a ();
    instr_mem_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_b ();
    instr_mem_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_c ();
    instr_mem_pipelined_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_d ();

    instr_mem_pipelined #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(1024),
        .READ_LATENCY(1), .FILL_WORD(16'hF025))
        dut_a (.clock(clock), .reset(rst_a), .bus(bus_a));
    instr_mem_pipelined #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(8192),
        .READ_LATENCY(3), .FILL_WORD(16'h0000))
        dut_b (.clock(clock), .reset(rst_b), .bus(bus_b));
    instr_mem_pipelined #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(1024),
        .READ_LATENCY(4), .FILL_WORD(16'h0000))
        dut_c (.clock(clock), .reset(rst_c), .bus(bus_c));
    instr_mem_pipelined #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256),
        .READ_LATENCY(2), .FILL_WORD(16'h0000))
        dut_d (.clock(clock), .reset(rst_d), .bus(bus_d));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic [15:0] la;
        logic [15:0] ldat;
        logic        rd;
        logic [15:0] pc;
        logic        ev;
        logic [15:0] ed;
        logic        ee;
        logic        ele;
    } vec_t;

    vec_t        tv [12];
    logic [15:0] ref_mem [1024];
    int          ref_count;
    logic [15:0] ref_dout;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all;
        bus_a.load_en = 0; bus_a.load_addr = 0; bus_a.load_data = 0; bus_a.rd_en = 0; bus_a.pc = 0;
        bus_b.load_en = 0; bus_b.load_addr = 0; bus_b.load_data = 0; bus_b.rd_en = 0; bus_b.pc = 0;
        bus_c.load_en = 0; bus_c.load_addr = 0; bus_c.load_data = 0; bus_c.rd_en = 0; bus_c.pc = 0;
        bus_d.load_en = 0; bus_d.load_addr = 0; bus_d.load_data = 0; bus_d.rd_en = 0; bus_d.pc = 0;
    endtask

    initial begin
        logic [15:0] b_words [4];
        logic [15:0] d_exp;
        logic        exp_v, exp_e, exp_le;
        logic [15:0] exp_d;
        logic        a_ld, a_rd;
        logic [15:0] a_la, a_ldat, a_pc;

        idle_all();
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
        step();
        // Reset values while reset is held
        chk("rst_dout",  32'(bus_a.instr_dout), 32'h0);
        chk("rst_valid", 32'(bus_a.instr_valid), 32'h0);
        chk("rst_aerr",  32'(bus_a.addr_err), 32'h0);
        chk("rst_lerr",  32'(bus_a.load_err), 32'h0);
        chk("rst_count", 32'(bus_a.rd_count), 32'h0);
        step();
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;

        // ---------------- vector table on dut_a (latency 1) ----------------
        tv[0]  = '{1'b1, 16'h0005, 16'h0011, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 16'h0000, 16'h2222, 1'b1, 16'h0005, 1'b1, 16'h0011, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 16'h03FF, 16'hBEEF, 1'b1, 16'h0005, 1'b1, 16'h0011, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 16'h0005, 16'h00AA, 1'b1, 16'h0005, 1'b1, 16'h0011, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h00AA, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h03FF, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0400, 1'b1, 16'hF025, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 16'h0400, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'hF025, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 16'hF025, 1'b1, 1'b0};
        tv[10] = '{1'b1, 16'hFFFF, 16'h5555, 1'b1, 16'h03FF, 1'b1, 16'hBEEF, 1'b0, 1'b1};
        tv[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            bus_a.load_en = tv[i].ld; bus_a.load_addr = tv[i].la; bus_a.load_data = tv[i].ldat;
            bus_a.rd_en = tv[i].rd; bus_a.pc = tv[i].pc;
            step();
            chk($sformatf("tv%0d_valid", i), 32'(bus_a.instr_valid), 32'(tv[i].ev));
            chk($sformatf("tv%0d_dout", i),  32'(bus_a.instr_dout),  32'(tv[i].ed));
            chk($sformatf("tv%0d_aerr", i),  32'(bus_a.addr_err),    32'(tv[i].ee));
            chk($sformatf("tv%0d_lerr", i),  32'(bus_a.load_err),    32'(tv[i].ele));
        end
        chk("tv_count", 32'(bus_a.rd_count), 32'd9);
        idle_all();

        // ---------------- preload + back-to-back reads, latency 3 ----------------
        b_words[0] = 16'h1234; b_words[1] = 16'h5678; b_words[2] = 16'h9ABC; b_words[3] = 16'hDEF0;
        for (int i = 0; i < 4; i++) begin
            bus_b.load_en = 1; bus_b.load_addr = 16'(16'h1000 + i); bus_b.load_data = b_words[i];
            step();
        end
        bus_b.load_en = 0;
        for (int c = 0; c < 9; c++) begin
            bus_b.rd_en = (c < 4);
            bus_b.pc = 16'(16'h1000 + c);
            step();
            // request driven in cycle j becomes visible after edge j+3 (iteration j+2)
            chk($sformatf("b_valid_c%0d", c), 32'(bus_b.instr_valid), 32'((c >= 2) && (c <= 5)));
            if ((c >= 2) && (c <= 5))
                chk($sformatf("b_dout_c%0d", c), 32'(bus_b.instr_dout), 32'(b_words[c-2]));
        end
        chk("b_count", 32'(bus_b.rd_count), 32'd4);
        bus_b.rd_en = 0;

        // ---------------- reset mid-flight, latency 4 ----------------
        bus_c.load_en = 1; bus_c.load_addr = 16'h0007; bus_c.load_data = 16'h7777;
        step();
        bus_c.load_en = 0;
        for (int i = 0; i < 3; i++) begin
            bus_c.rd_en = 1; bus_c.pc = 16'h0007;
            step();
        end
        bus_c.rd_en = 0;
        rst_c = 1;
        #2;
        chk("c_rst_valid", 32'(bus_c.instr_valid), 32'h0);
        chk("c_rst_dout",  32'(bus_c.instr_dout), 32'h0);
        chk("c_rst_count", 32'(bus_c.rd_count), 32'h0);
        step();
        rst_c = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("c_post_valid%0d", i), 32'(bus_c.instr_valid), 32'h0);
        end
        chk("c_post_dout",  32'(bus_c.instr_dout), 32'h0);
        chk("c_post_aerr",  32'(bus_c.addr_err), 32'h0);
        chk("c_post_lerr",  32'(bus_c.load_err), 32'h0);
        chk("c_post_count", 32'(bus_c.rd_count), 32'h0);
        bus_c.rd_en = 1; bus_c.pc = 16'h0007;
        step();
        bus_c.rd_en = 0;
        chk("c_rd_valid_e0", 32'(bus_c.instr_valid), 32'h0);
        step();
        chk("c_rd_valid_e1", 32'(bus_c.instr_valid), 32'h0);
        step();
        chk("c_rd_valid_e2", 32'(bus_c.instr_valid), 32'h0);
        step();
        chk("c_rd_valid_e3", 32'(bus_c.instr_valid), 32'h1);
        chk("c_rd_dout",     32'(bus_c.instr_dout), 32'h7777);
        chk("c_rd_count",    32'(bus_c.rd_count), 32'h1);

        // ---------------- sparse requests, latency 2 ----------------
        for (int i = 1; i <= 3; i++) begin
            bus_d.load_en = 1; bus_d.load_addr = 16'(i); bus_d.load_data = 16'(16'hD000 + i);
            step();
        end
        bus_d.load_en = 0;
        d_exp = 16'h0000;
        for (int c = 0; c < 12; c++) begin
            bus_d.rd_en = (c == 0) || (c == 2) || (c == 7);
            bus_d.pc = (c == 0) ? 16'h1 : (c == 2) ? 16'h2 : 16'h3;
            step();
            // after this edge the bench is in cycle c+1
            if (c + 1 == 2) d_exp = 16'hD001;
            if (c + 1 == 4) d_exp = 16'hD002;
            if (c + 1 == 9) d_exp = 16'hD003;
            chk($sformatf("d_valid_cy%0d", c + 1), 32'(bus_d.instr_valid),
                32'((c + 1 == 2) || (c + 1 == 4) || (c + 1 == 9)));
            chk($sformatf("d_dout_cy%0d", c + 1), 32'(bus_d.instr_dout), 32'(d_exp));
        end
        bus_d.rd_en = 0;

        // ---------------- randomized run against memory model on dut_a ----------------
        rst_a = 1;
        step();
        rst_a = 0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 16'($urandom);
            bus_a.load_en = 1; bus_a.load_addr = 16'(i); bus_a.load_data = ref_mem[i];
            step();
        end
        bus_a.load_en = 0;
        ref_count = 0;
        ref_dout = 16'h0000;
        for (int i = 0; i < 2000; i++) begin
            a_ld   = ($urandom_range(0, 2) == 0);
            a_la   = 16'($urandom_range(0, 1199));
            a_ldat = 16'($urandom);
            a_rd   = ($urandom_range(0, 3) != 0);
            a_pc   = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 1199));
            bus_a.load_en = a_ld; bus_a.load_addr = a_la; bus_a.load_data = a_ldat;
            bus_a.rd_en = a_rd; bus_a.pc = a_pc;
            // reads observe the contents before this cycle's load
            exp_le = a_ld && (a_la >= 16'd1024);
            exp_v  = a_rd;
            exp_e  = a_rd && (a_pc >= 16'd1024);
            if (a_rd) begin
                exp_d = exp_e ? 16'hF025 : ref_mem[a_pc[9:0]];
                if (ref_count < 65535) ref_count++;
            end else begin
                exp_d = ref_dout;
            end
            if (a_ld && (a_la < 16'd1024)) ref_mem[a_la[9:0]] = a_ldat;
            ref_dout = exp_d;
            step();
            chk($sformatf("r%0d_valid", i), 32'(bus_a.instr_valid), 32'(exp_v));
            chk($sformatf("r%0d_dout", i),  32'(bus_a.instr_dout),  32'(exp_d));
            chk($sformatf("r%0d_aerr", i),  32'(bus_a.addr_err),    32'(exp_e));
            chk($sformatf("r%0d_lerr", i),  32'(bus_a.load_err),    32'(exp_le));
            chk($sformatf("r%0d_count", i), 32'(bus_a.rd_count),    32'(ref_count));
        end
        idle_all();

        // ---------------- counter saturation on dut_a ----------------
        rst_a = 1;
        step();
        rst_a = 0;
        bus_a.rd_en = 1; bus_a.pc = 16'h0003;
        for (int i = 1; i <= 65537; i++) begin
            step();
            if (i == 65534) chk("sat_count_fffe", 32'(bus_a.rd_count), 32'hFFFE);
            if (i == 65535) chk("sat_count_ffff", 32'(bus_a.rd_count), 32'hFFFF);
        end
        chk("sat_count_final", 32'(bus_a.rd_count), 32'hFFFF);
        chk("sat_last_valid",  32'(bus_a.instr_valid), 32'h1);
        chk("sat_last_dout",   32'(bus_a.instr_dout), 32'(ref_mem[3]));
        bus_a.rd_en = 0;
        step();
        chk("sat_idle_valid", 32'(bus_a.instr_valid), 32'h0);
        chk("sat_idle_count", 32'(bus_a.rd_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_pipelined.md
# instr_mem_pipelined

Parametrised synthesizable instruction-memory model that serves the LC3 fetch stage. It accepts one fetch request per cycle and returns the word after a configurable fixed read latency. It also offers a side-band load port for program preload, plus out-of-range detection. It replaces the fixed single-cycle, single-width instruction store in the instruction_memory environment and sits between the DUT fetch port and the instruction_memory BFM.

## Interface
- ADDR_WIDTH, 16, width of pc and load_addr
- DATA_WIDTH, 16, instruction word width
- DEPTH, 1024, number of words; legal range 1..2**ADDR_WIDTH
- READ_LATENCY, 1, cycles from accepted request to instr_valid; legal 1..4
- FILL_WORD, 0, data returned for out-of-range reads
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears the pipeline and counters, not the array
- load_en  in  1  write load_data to load_addr this cycle
- load_addr  in  ADDR_WIDTH  preload address
- load_data  in  DATA_WIDTH  preload word
- rd_en  in  1  fetch request, sampled each cycle
- pc  in  ADDR_WIDTH  fetch address
- instr_dout  out  DATA_WIDTH  returned instruction
- instr_valid  out  1  one-cycle pulse per accepted request
- addr_err  out  1  pulse aligned with instr_valid when that request was out of range
- load_err  out  1  pulse the cycle after a load_en with load_addr >= DEPTH
- rd_count  out  16  saturating count of accepted requests

## Operation
- Storage is an array of DEPTH words of DATA_WIDTH. Contents are undefined at power-up and retained across reset.
- Load: if load_en=1 and load_addr < DEPTH, write on the clock edge. If load_addr >= DEPTH, no write occurs and load_err pulses the next cycle.
- Read: every cycle with rd_en=1 is an accepted request; there is no backpressure.
- The request enters a READ_LATENCY-deep shift pipeline carrying {valid, err, data}.
- Out of range (pc >= DEPTH): the returned data is FILL_WORD and addr_err=1 with the response.
- Same-cycle load and read to the same address: the read returns the OLD word (read-before-write). The new word is visible to requests issued from the next cycle on.
- Responses are returned in request order, one per request. Back-to-back requests give back-to-back valid pulses.
- instr_dout holds the last returned word while instr_valid=0.
- rd_count increments on each accepted request and saturates at 16'hFFFF.
- rd_en and load_en are independent and may be asserted together every cycle.

## Timing
- Reset values:
  - instr_dout=0
  - instr_valid=0
  - addr_err=0
  - load_err=0
  - rd_count=0
  - all pipeline valid bits 0
- Asserting reset clears outputs immediately (asynchronous). In-flight requests are discarded; no instr_valid is emitted for them after reset deasserts.
- A request accepted at edge N produces instr_valid=1 and instr_dout in the cycle following edge N+READ_LATENCY-1. With READ_LATENCY=1 the data is registered one cycle after the request.
- A request in the first cycle after reset deassertion is accepted normally.
- Throughput is 1 request per cycle, so the pipeline holds at most READ_LATENCY responses in flight.
- The pc range check is a full-width compare; it wraps only when DEPTH == 2**ADDR_WIDTH, in which case it never errors.
- rd_count saturating case: a request with rd_count=16'hFFFF keeps it at 16'hFFFF and is still served.

## Test plan
- Preload: load 0x1000..0x1003 with 0x1234, 0x5678, 0x9ABC, 0xDEF0, then issue 4 back-to-back reads with READ_LATENCY=3.
  - Required: 4 consecutive valid pulses starting 3 cycles after the first request, data in order, rd_count=4.
  - This requires DEPTH >= 0x1004; set DEPTH accordingly for this test.
- Same-cycle load 0x00AA to address 5 (old value 0x0011) together with a read of address 5 -> returns 0x0011. A read of address 5 in the next cycle returns 0x00AA.
- Out-of-range read, DEPTH=1024, pc=0x0400, FILL_WORD=0xF025 -> instr_dout=0xF025 with addr_err=1. A load to 0x0400 produces load_err=1 and the array is unchanged.
- Reset mid-flight: READ_LATENCY=4, 3 requests issued, reset pulsed on the next cycle.
  - Required: no instr_valid at any time afterwards, all outputs 0, and a subsequent preloaded read returns the pre-reset contents.
- Sparse requests: rd_en high on cycles 0, 2 and 7 with READ_LATENCY=2 -> valid pulses on cycles 2, 4 and 9 only. instr_dout holds its value in between.
- Counter saturation: force 65537 requests -> rd_count=0xFFFF and the last request is still served.
